// File: rtl/mdc_multiport_addr_gen.sv
// Multi-port address generator: round-robin bursts from a shared local-memory read port into per-port FIFOs.
// Optional build macro MDC_ADDR_CHECK_EN drops out-of-range channels at start and raises a sticky err.
module mdc_multiport_addr_gen #(
    parameter int NPORTS      = 4,
    parameter int SIZEPORT    = 2,
    parameter int SIZEDATA    = 32,
    parameter int SIZEADDRESS = 12,
    parameter int SIZECOUNT   = 12,
    parameter int SIZEBURST   = 8,
    parameter int SIZEID      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SIZEDATA-1:0]    confin,
    input  logic [SIZEPORT-1:0]    conf_sel,
    input  logic                   conf_en,
    input  logic [SIZEID-1:0]      kernelIDin,
    input  logic                   start,
    output logic [SIZEID-1:0]      kernelIDout,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   mem_en,
    output logic [SIZEADDRESS-1:0] mem_addr,
    input  logic [SIZEDATA-1:0]    mem_data,
    input  logic [NPORTS-1:0]      out_ready,
    output logic                   out_valid,
    output logic [SIZEPORT-1:0]    out_port,
    output logic [SIZEDATA-1:0]    out_data
);

    localparam int LW = (SIZEBURST > SIZECOUNT) ? SIZEBURST : SIZECOUNT;
    localparam logic [SIZEPORT:0] NP   = (SIZEPORT+1)'(NPORTS);
    localparam logic [SIZEPORT:0] LAST = (SIZEPORT+1)'(NPORTS-1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_BURST, S_DRAIN, S_DONE} state_t;

    state_t                 r_state;
    logic [SIZEADDRESS-1:0] r_base  [NPORTS];
    logic [SIZECOUNT-1:0]   r_size  [NPORTS];
    logic [SIZEBURST-1:0]   r_burst [NPORTS];
    logic [SIZEADDRESS-1:0] r_addr  [NPORTS];
    logic [SIZECOUNT-1:0]   r_rem   [NPORTS];
    logic [SIZEPORT-1:0]    r_rr;
    logic [SIZEPORT-1:0]    r_gnt;
    logic [LW-1:0]          r_left;
    logic [SIZEID-1:0]      r_kid;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_mem_en;
    logic [SIZEADDRESS-1:0] r_mem_addr;
    logic                   r_out_valid;
    logic [SIZEPORT-1:0]    r_out_port;

    logic [NPORTS-1:0]      w_ch_ok;
    logic                   w_any_act;
    logic                   w_any_rem;
    logic                   w_found;
    logic [SIZEPORT-1:0]    w_gnt;
    logic [LW-1:0]          w_burst1;
    logic [LW-1:0]          w_len;

    function automatic logic [SIZEPORT-1:0] f_wrap(input int v);
        return SIZEPORT'(v % NPORTS);
    endfunction

`ifdef MDC_ADDR_CHECK_EN
    localparam int AW = ((SIZEADDRESS > SIZECOUNT) ? SIZEADDRESS : SIZECOUNT) + 1;
    localparam logic [AW-1:0] SPAN = AW'(1) << SIZEADDRESS;
    logic r_err;
    logic w_viol;

    // A channel is in range when its last address does not pass the top of memory.
    always_comb begin
        w_viol = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            w_ch_ok[i] = (AW'(r_base[i]) + AW'(r_size[i])) <= SPAN;
            if (r_size[i] != '0 && !w_ch_ok[i]) w_viol = 1'b1;
        end
    end
    assign err = r_err;
`else
    assign w_ch_ok = '1;
    assign err     = 1'b0;
`endif

    always_comb begin
        w_any_act = 1'b0;
        w_any_rem = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (r_size[i] != '0 && w_ch_ok[i]) w_any_act = 1'b1;
            if (r_rem[i] != '0)                w_any_rem = 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    // Descending scan: the last hit is the first eligible channel at or after r_rr.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int i = NPORTS-1; i >= 0; i--) begin
            if (r_rem[f_wrap(int'(r_rr) + i)] != '0 && out_ready[f_wrap(int'(r_rr) + i)]) begin
                w_found = 1'b1;
                w_gnt   = f_wrap(int'(r_rr) + i);
            end
        end
        w_burst1 = (r_burst[w_gnt] == '0) ? LW'(1) : LW'(r_burst[w_gnt]);
        w_len    = (w_burst1 < LW'(r_rem[w_gnt])) ? w_burst1 : LW'(r_rem[w_gnt]);
    end

    // NOTE: the small config/counter arrays are reset because their zero state is architecturally visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_gnt       <= '0;
            r_left      <= '0;
            r_kid       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_out_valid <= 1'b0;
            r_out_port  <= '0;
`ifdef MDC_ADDR_CHECK_EN
            r_err       <= 1'b0;
`endif
            for (int i = 0; i < NPORTS; i++) begin
                r_base[i]  <= '0;
                r_size[i]  <= '0;
                r_burst[i] <= '0;
                r_addr[i]  <= '0;
                r_rem[i]   <= '0;
            end
        end else begin
            r_out_valid <= r_mem_en;
            r_out_port  <= r_gnt;
            case (r_state)
                S_IDLE: begin
                    if (conf_en && ({1'b0, conf_sel} < NP)) begin
                        r_base[conf_sel]  <= confin[SIZEADDRESS-1:0];
                        r_size[conf_sel]  <= confin[SIZEADDRESS+SIZECOUNT-1:SIZEADDRESS];
                        r_burst[conf_sel] <= confin[SIZEADDRESS+SIZECOUNT+SIZEBURST-1:SIZEADDRESS+SIZECOUNT];
                    end
                    if (start) begin
                        r_kid <= kernelIDin;
`ifdef MDC_ADDR_CHECK_EN
                        r_err <= w_viol;
`endif
                        for (int i = 0; i < NPORTS; i++) begin
                            r_addr[i] <= r_base[i];
                            r_rem[i]  <= w_ch_ok[i] ? r_size[i] : '0;
                        end
                        if (w_any_act) begin
                            r_state <= S_ARB;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_ARB: begin
                    if (w_found) begin
                        r_gnt             <= w_gnt;
                        r_mem_en          <= 1'b1;
                        r_mem_addr        <= r_addr[w_gnt];
                        r_addr[w_gnt]     <= r_addr[w_gnt] + SIZEADDRESS'(1);
                        r_rem[w_gnt]      <= r_rem[w_gnt] - SIZECOUNT'(1);
                        r_left            <= w_len - LW'(1);
                        r_state           <= S_BURST;
                    end else if (!w_any_rem) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_BURST: begin
                    if (r_left != '0) begin
                        r_mem_en      <= 1'b1;
                        r_mem_addr    <= r_addr[r_gnt];
                        r_addr[r_gnt] <= r_addr[r_gnt] + SIZEADDRESS'(1);
                        r_rem[r_gnt]  <= r_rem[r_gnt] - SIZECOUNT'(1);
                        r_left        <= r_left - LW'(1);
                    end else begin
                        r_mem_en <= 1'b0;
                        r_rr     <= ({1'b0, r_gnt} == LAST) ? '0 : r_gnt + SIZEPORT'(1);
                        r_state  <= S_DRAIN;
                    end
                end
                S_DRAIN: r_state <= S_ARB;
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign kernelIDout = r_kid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_en      = r_mem_en;
    assign mem_addr    = r_mem_addr;
    assign out_valid   = r_out_valid;
    assign out_port    = r_out_port;
    assign out_data    = r_out_valid ? mem_data : '0;

endmodule

// File: tb/tb_mdc_multiport_addr_gen.sv
// Bench for mdc_multiport_addr_gen: per-channel queue/arbitration model checked every cycle, plus directed scenarios.
`timescale 1ns/1ps
module tb_mdc_multiport_addr_gen;
    localparam int NP = 4, SP = 2, SD = 32, SA = 12, SC = 12, SB = 8, SI = 8;
    localparam int MEMSZ = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SD-1:0] confin = '0;
    logic [SP-1:0] conf_sel = '0;
    logic          conf_en = 1'b0;
    logic [SI-1:0] kernelIDin = '0;
    logic          start = 1'b0;
    logic [SI-1:0] kernelIDout;
    logic          busy, done, err, mem_en, out_valid;
    logic [SA-1:0] mem_addr;
    logic [SD-1:0] mem_data;
    logic [NP-1:0] out_ready = '1;
    logic [SP-1:0] out_port;
    logic [SD-1:0] out_data;

    mdc_multiport_addr_gen #(
        .NPORTS(NP), .SIZEPORT(SP), .SIZEDATA(SD), .SIZEADDRESS(SA),
        .SIZECOUNT(SC), .SIZEBURST(SB), .SIZEID(SI)
    ) dut (
        .clk(clk), .rst(rst), .confin(confin), .conf_sel(conf_sel), .conf_en(conf_en),
        .kernelIDin(kernelIDin), .start(start), .kernelIDout(kernelIDout), .busy(busy),
        .done(done), .err(err), .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_port(out_port), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Memory preloaded with mem[a] = a, one cycle read latency.
    always @(posedge clk) if (mem_en) mem_data <= SD'(mem_addr);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: configs, per-channel next address and words left, round-robin pointer.
    int  m_base[NP], m_size[NP], m_burst[NP], m_addr[NP], m_rem[NP];
    int  m_rr = 0, m_ch = 0, m_left = 0, cur_len = 0, m_kid = 0;
    bit  m_err = 0;
    bit  exp_v = 0;
    int  exp_p = 0, exp_d = 0;
    bit  chk_en = 0;
    bit  prev_done = 0;
    int  idle_cnt = 0, bursts = 0, done_cnt = 0, cyc = 0, rise_cyc = 0;
    logic [NP-1:0] prev_ready;
    int  blen_q[$], obs_d[$], obs_p[$], obs_c[$];

    always @(negedge clk) begin
        int g;
        int rem_sum;
        cyc++;
        if (chk_en) begin
            check("out_valid", out_valid, exp_v);
            if (exp_v) begin
                check("out_port", out_port, exp_p);
                check("out_data", out_data, exp_d);
            end
            if (out_valid) begin
                obs_d.push_back(int'(out_data));
                obs_p.push_back(int'(out_port));
                obs_c.push_back(cyc);
            end
            check("kernelIDout", kernelIDout, m_kid);
            check("err", err, m_err);
            exp_v = 0;
            if (m_left != 0) check("mem_en_in_burst", mem_en, 1);
            if (mem_en) begin
                check("busy_during_read", busy, 1);
                if (m_left == 0) begin
                    g = -1;
                    for (int i = NP-1; i >= 0; i--)
                        if (m_rem[(m_rr+i)%NP] > 0 && prev_ready[(m_rr+i)%NP]) g = (m_rr+i)%NP;
                    check("grant_eligible", g >= 0, 1);
                    if (bursts > 0) check("burst_gap_ge2", idle_cnt >= 2, 1);
                    if (g >= 0) begin
                        m_ch   = g;
                        m_left = (m_burst[g] == 0) ? 1 : m_burst[g];
                        if (m_left > m_rem[g]) m_left = m_rem[g];
                    end
                    bursts++;
                end
                if (m_left > 0) begin
                    check("mem_addr", mem_addr, m_addr[m_ch]);
                    exp_v = 1;
                    exp_p = m_ch;
                    exp_d = m_addr[m_ch];
                    m_addr[m_ch] = (m_addr[m_ch] + 1) % MEMSZ;
                    m_rem[m_ch]--;
                    m_left--;
                    cur_len++;
                    if (m_left == 0) begin
                        m_rr = (m_ch + 1) % NP;
                        blen_q.push_back(cur_len);
                        cur_len = 0;
                    end
                end
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
            if (done) begin
                rem_sum = m_left;
                for (int i = 0; i < NP; i++) rem_sum += m_rem[i];
                check("done_all_drained", rem_sum, 0);
                check("done_single_cycle", prev_done, 0);
                check("busy_low_at_done", busy, 0);
                done_cnt++;
            end
            prev_done = done;
        end
        prev_ready = out_ready;
    end

    task automatic cfg(input int ch, input int base, input int size, input int burst, input bit accept);
        @(posedge clk); #1;
        conf_en  = 1'b1;
        conf_sel = SP'(ch);
        confin   = {SB'(burst), SC'(size), SA'(base)};
        @(posedge clk); #1;
        conf_en  = 1'b0;
        if (accept) begin
            m_base[ch] = base; m_size[ch] = size; m_burst[ch] = burst;
        end
    endtask

    task automatic do_start(input int kid, input bit accept);
        @(posedge clk); #1;
        start = 1'b1;
        kernelIDin = SI'(kid);
        @(posedge clk); #1;
        start = 1'b0;
        if (accept) begin
            m_kid = kid; m_err = 0; bursts = 0;
            for (int i = 0; i < NP; i++) begin
                m_addr[i] = m_base[i];
                m_rem[i]  = m_size[i];
`ifdef MDC_ADDR_CHECK_EN
                if (m_size[i] != 0 && m_base[i] + m_size[i] > MEMSZ) begin
                    m_rem[i] = 0;
                    m_err = 1;
                end
`endif
            end
        end
    endtask

    // mode 0: leave out_ready, 1: randomise every cycle, 2: raise all bits after 20 cycles.
    task automatic wait_done(input int max_cyc, input int mode);
        int base_cnt;
        int n;
        base_cnt = done_cnt;
        n = 0;
        while (done_cnt == base_cnt && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
            if (mode == 1) out_ready = NP'($urandom);
            else if (mode == 2 && n == 20) begin
                out_ready = '1;
                rise_cyc = cyc;
            end
        end
        check("done_within_bound", done_cnt != base_cnt, 1);
        @(posedge clk); #1;
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_port"}, out_port, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_kernelIDout"}, kernelIDout, 0);
    endtask

    task automatic reset_model();
        for (int i = 0; i < NP; i++) begin
            m_base[i] = 0; m_size[i] = 0; m_burst[i] = 0; m_addr[i] = 0; m_rem[i] = 0;
        end
        m_rr = 0; m_left = 0; cur_len = 0; m_kid = 0; m_err = 0; exp_v = 0;
        prev_done = 0; bursts = 0;
    endtask

    task automatic clear_obs();
        obs_d.delete(); obs_p.delete(); obs_c.delete(); blen_q.delete();
    endtask

    task automatic expect_immediate_done(input int kid);
        clear_obs();
        do_start(kid, 1);
        @(negedge clk); #1;
        check("immediate_done", done, 1);
        check("immediate_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("immediate_no_words", obs_d.size(), 0);
    endtask

    initial begin
        int n;
        int cnt;
        int late;
        reset_model();
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Scenario 1: four channels, size 4, burst 1, all ready.
        clear_obs();
        out_ready = 4'hF;
        for (int c = 0; c < NP; c++) cfg(c, c*10, 4, 1, 1);
        do_start(1, 1);
        check("s1_kernelIDout", kernelIDout, 1);
        wait_done(400, 0);
        check("s1_words", obs_d.size(), 16);
        for (int k = 0; k < 16 && k < obs_d.size(); k++)
            check("s1_data_order", obs_d[k], (k % 4) * 10 + k / 4);

        // Scenario 2: single channel, size 5, burst 2 -> bursts 2,2,1.
        clear_obs();
        cfg(0, 0, 5, 2, 1);
        for (int c = 1; c < NP; c++) cfg(c, 0, 0, 0, 1);
        do_start(2, 1);
        wait_done(200, 0);
        check("s2_words", obs_d.size(), 5);
        for (int k = 0; k < obs_d.size(); k++) begin
            check("s2_data", obs_d[k], k);
            check("s2_port", obs_p[k], 0);
        end
        check("s2_nbursts", blen_q.size(), 3);
        if (blen_q.size() == 3) begin
            check("s2_blen0", blen_q[0], 2);
            check("s2_blen1", blen_q[1], 2);
            check("s2_blen2", blen_q[2], 1);
        end

        // Scenario 3: channel 1 not ready until 20 cycles after start.
        clear_obs();
        for (int c = 0; c < NP; c++) cfg(c, c*10, 4, 1, 1);
        out_ready = 4'b1101;
        do_start(3, 1);
        wait_done(400, 2);
        check("s3_words", obs_d.size(), 16);
        cnt = 0; late = 1;
        for (int k = 0; k < obs_p.size(); k++)
            if (obs_p[k] == 1) begin
                cnt++;
                if (obs_c[k] <= rise_cyc) late = 0;
            end
        check("s3_port1_words", cnt, 4);
        check("s3_port1_after_ready", late, 1);

        // Scenario 4: nothing active.
        for (int c = 0; c < NP; c++) cfg(c, 7, 0, 3, 1);
        expect_immediate_done(4);

        // Scenario 5: config/start ignored while busy, re-start, then reset mid-burst.
        clear_obs();
        for (int c = 0; c < NP; c++) cfg(c, 40 + c*8, 4, 2, 1);
        do_start(5, 1);
        repeat (6) @(posedge clk);
        #1;
        check("s5_busy_mid", busy, 1);
        cfg(0, 100, 9, 1, 0);
        do_start(9, 0);
        wait_done(400, 0);
        check("s5_words", obs_d.size(), 16);
        do_start(6, 1);
        n = 0;
        while (!mem_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("s5_mem_en_before_rst", mem_en, 1);
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        reset_model();
        chk_en = 1'b1;
        expect_immediate_done(8);

        // Scenario 6: channel 2 runs past the top of memory.
        clear_obs();
        cfg(0, 100, 3, 2, 1);
        cfg(1, 200, 2, 1, 1);
        cfg(2, 4090, 8, 3, 1);
        cfg(3, 0, 0, 1, 1);
        do_start(10, 1);
`ifdef MDC_ADDR_CHECK_EN
        check("s6_err_set", err, 1);
`else
        check("s6_err_tied", err, 0);
`endif
        wait_done(400, 0);
        cnt = 0;
        for (int k = 0; k < obs_p.size(); k++) if (obs_p[k] == 2) cnt++;
`ifdef MDC_ADDR_CHECK_EN
        check("s6_port2_words", cnt, 0);
        check("s6_words", obs_d.size(), 5);
`else
        check("s6_port2_words", cnt, 8);
        check("s6_words", obs_d.size(), 13);
`endif

        // Randomised rounds with per-cycle random out_ready.
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < NP; c++)
                cfg(c, ($urandom_range(0, 3) == 0) ? int'($urandom_range(4086, 4095)) : int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 4)), 1);
            do_start(int'($urandom_range(0, 255)), 1);
            wait_done(3000, 1);
        end
        out_ready = '1;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
